// File: rtl/pipe_hilo_if.sv
// Decode-side interface of the HI/LO unit: mult/div requests, HI/LO moves and read-back.
interface pipe_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             mfhi;
    logic             mflo;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, mthi, mtlo, wdata, mfhi, mflo,
        input  rdata, busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, mthi, mtlo, wdata, mfhi, mflo,
        output rdata, busy, stall, done, hi, lo
    );
endinterface

// File: rtl/pipe_hilo_unit.sv
// Architectural HI/LO registers with an iterative one-bit-per-cycle multiply/divide engine.
// Operands are reduced to magnitudes on entry; the sign is restored in a final FIX cycle.
module pipe_hilo_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    pipe_hilo_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    // Operand magnitudes; op[0]=0 selects the signed variants.
    logic             sgn_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign sgn_op = ~bus.op[0];
    assign a_mag  = (sgn_op && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag  = (sgn_op && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

    // Shift-add step: acc holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_nx;
    assign mul_sum = {1'b0, acc[AW-1:WIDTH]} + {1'b0, opnd};
    assign mul_nx  = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                            : {1'b0, acc[AW-1:WIDTH], acc[WIDTH-1:1]};

    // Restoring divide step: acc holds {remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [AW-1:0]    div_nx;
    assign div_sh   = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_sh[WIDTH-1:0] - opnd;
    assign div_ge   = div_sh >= {1'b0, opnd};
    assign div_nx   = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                             : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    // Sign correction applied while in FIX.
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    assign prod_fix = neg_q ? (~acc + AW'(1)) : acc;
    assign quo_fix  = div_zero ? '1 :
                      neg_q    ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? (~acc[AW-1:WIDTH] + WIDTH'(1)) : acc[AW-1:WIDTH];
    assign res_hi   = is_div ? rem_fix : prod_fix[AW-1:WIDTH];
    assign res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    // Datapath, HI/LO and status registers; flush cancels any write or launch this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state == FIX) && !bus.flush;
            if (!bus.flush) begin
                case (state)
                    IDLE: begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                        if (bus.start) begin
                            cnt      <= '0;
                            is_div   <= bus.op[1];
                            div_zero <= bus.op[1] && (bus.b == '0);
                            neg_q    <= sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_r    <= sgn_op && bus.a[WIDTH-1];
                            acc      <= bus.op[1] ? {WIDTH'(0), a_mag} : {WIDTH'(0), b_mag};
                            opnd     <= bus.op[1] ? b_mag : a_mag;
                        end
                    end
                    CALC: begin
                        acc <= is_div ? div_nx : mul_nx;
                        cnt <= cnt + CW'(1);
                    end
                    FIX: begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & (bus.start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo);
    assign bus.rdata = bus.mfhi ? hi_q : bus.mflo ? lo_q : '0;
endmodule

// File: tb/tb_pipe_hilo_unit.sv
// Bench for pipe_hilo_unit: directed literal cases plus randomized traffic against a
// transaction-level model that computes results with native 64-bit arithmetic.
module tb_pipe_hilo_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hilo_if #(.WIDTH(32)) bus ();
    pipe_hilo_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results from plain arithmetic; covers divide-by-zero and signed overflow.
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int signed          sa, sb;
        h = '0; l = '0;
        case (op)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                h = sp[63:32]; l = sp[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                h = up[63:32]; l = up[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin h = a; l = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = '0; l = 32'h8000_0000; end
                else begin
                    sa = $signed(a); sb = $signed(b);
                    l = 32'(sa / sb); h = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 32'd0) begin h = a; l = '1; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    // Model: a request seen while idle completes 33 edges later unless flushed.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (bus.flush) begin
                m_busy = 1'b0; m_left = 0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = r_hi; m_lo = r_lo; m_done = 1'b1; m_busy = 1'b0;
                end
            end else begin
                if (bus.mthi) m_hi = bus.wdata;
                if (bus.mtlo) m_lo = bus.wdata;
                if (bus.start) begin
                    ref_op(bus.op, bus.a, bus.b, r_hi, r_lo);
                    m_busy = 1'b1; m_left = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
            chk("busy", {31'b0, bus.busy}, {31'b0, m_busy});
            chk("done", {31'b0, bus.done}, {31'b0, m_done});
            chk("stall", {31'b0, bus.stall},
                {31'b0, m_busy & (bus.start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo)});
            if (!m_busy)
                chk("rdata", bus.rdata, bus.mfhi ? m_hi : bus.mflo ? m_lo : 32'd0);
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            bus.start = 1'b0;
            if (n == 10) begin
                bus.mflo = 1'b1; #1;
                chk("stall_busy_mflo", {31'b0, bus.stall}, 32'd1);
                bus.mflo = 1'b0;
            end
            if (bus.done) seen = 1'b1;
        end
        chk("done_latency", 32'(n), 32'd34);
        chk("op_hi", bus.hi, exp_hi);
        chk("op_lo", bus.lo, exp_lo);
        chk("model_hi", m_hi, exp_hi);
        chk("model_lo", m_lo, exp_lo);
        bus.mflo = 1'b1; #1;
        chk("mflo_after_done", bus.rdata, exp_lo);
        chk("stall_idle", {31'b0, bus.stall}, 32'd0);
        bus.mfhi = 1'b1; #1;
        chk("mfhi_priority", bus.rdata, exp_hi);
        bus.mfhi = 1'b0; bus.mflo = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  k;
        bit  seen_done;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0; bus.mfhi = 0; bus.mflo = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(2'b11, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(2'b10, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op(2'b11, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Moves while idle: joint write, then HI only.
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        bus.mtlo = 1'b0; bus.wdata = 32'h0000_1234;
        chk("mthi_mtlo_hi", bus.hi, 32'hAAAA_5555);
        chk("mthi_mtlo_lo", bus.lo, 32'hAAAA_5555);
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        chk("mthi_hi", bus.hi, 32'h0000_1234);
        chk("mthi_lo", bus.lo, 32'hAAAA_5555);

        // mthi while busy is blocked; flush at cycle 15 cancels without done.
        bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        seen_done = 1'b0;
        for (k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) seen_done = 1'b1;
            if (k == 5) begin
                bus.mthi = 1'b1; bus.wdata = 32'h0000_5555; #1;
                chk("stall_busy_mthi", {31'b0, bus.stall}, 32'd1);
            end
            if (k == 6) begin
                bus.mthi = 1'b0;
                chk("mthi_busy_ignored", bus.hi, 32'h0000_1234);
            end
            if (k == 15) bus.flush = 1'b1;
            if (k == 16) begin
                bus.flush = 1'b0;
                chk("flush_busy", {31'b0, bus.busy}, 32'd0);
            end
        end
        chk("flush_no_done", {31'b0, seen_done}, 32'd0);
        chk("flush_hi_kept", bus.hi, 32'h0000_1234);
        chk("flush_lo_kept", bus.lo, 32'hAAAA_5555);

        // Asynchronous reset in the middle of a divide.
        bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; #1;
        chk("rst_mid_hi", bus.hi, 32'd0);
        chk("rst_mid_lo", bus.lo, 32'd0);
        chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.a     = pick_val();
            bus.b     = pick_val();
            bus.flush = ($urandom_range(0, 99) == 0);
            bus.mthi  = ($urandom_range(0, 7) == 0);
            bus.mtlo  = ($urandom_range(0, 7) == 0);
            bus.wdata = $urandom;
            bus.mfhi  = ($urandom_range(0, 3) == 0);
            bus.mflo  = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1;
        bus.start = 0; bus.flush = 0; bus.mthi = 0; bus.mtlo = 0; bus.mfhi = 0; bus.mflo = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
